// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types: element type, upsampler states, width helper.
// Imported by the fmap upsampler and its line buffer.
package cnn_pkg;

  localparam int DW_DEF = 18;

  typedef logic [DW_DEF-1:0] fmap_elem_t;

  typedef enum logic [2:0] {
    IDLE,
    ROW_IN,
    ROW_REP,
    ROW_DUP,
    FIN
  } ups_state_t;

  // counter width that stays >= 1 bit for degenerate sizes
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_line_buf.sv
// One-row line buffer: single synchronous write port, combinational read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module fmap_line_buf #(
  parameter int DEPTH = 224,
  parameter int WIDTH = 18,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fmap_upsample_unit.sv
// Streaming 2x2 nearest-neighbour upsampler over a raster (c, x, y) stream.
// Ports: clk, rst, start/busy/done, s_* input stream, m_* output stream.
module fmap_upsample_unit
  import cnn_pkg::*;
#(
  parameter int W_IN     = 14,
  parameter int H_IN     = 14,
  parameter int CHANNELS = 16,
  parameter int DW       = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  localparam int CW    = cw(CHANNELS);
  localparam int XW    = cw(W_IN);
  localparam int YW    = cw(H_IN);
  localparam int DEPTH = W_IN * CHANNELS;
  localparam int AW    = cw(DEPTH);

  localparam logic [CW-1:0] C_MAX = CW'(CHANNELS - 1);
  localparam logic [XW-1:0] X_MAX = XW'(W_IN - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(H_IN - 1);

  ups_state_t    state;
  logic [CW-1:0] c;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          rep;

  logic          adv;
  logic          s_fire;
  logic          c_last;
  logic          x_last;
  logic          y_last;
  logic [AW-1:0] addr;
  logic [DW-1:0] rd_data;

  // output register can take a new element this cycle
  assign adv    = !m_valid || m_ready;
  assign s_ready = (state == ROW_IN) && adv;
  assign s_fire = s_valid && s_ready;

  assign c_last = (c == C_MAX);
  assign x_last = (x == X_MAX);
  assign y_last = (y == Y_MAX);

  // same slot is written in ROW_IN and read back in ROW_REP/ROW_DUP
  assign addr = AW'(x) * AW'(CHANNELS) + AW'(c);

  fmap_line_buf #(
    .DEPTH(DEPTH),
    .WIDTH(DW),
    .AW   (AW)
  ) u_buf (
    .clk  (clk),
    .we   (s_fire),
    .waddr(addr),
    .wdata(s_data),
    .raddr(addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      c       <= '0;
      x       <= '0;
      y       <= '0;
      rep     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ROW_IN;
            busy  <= 1'b1;
            c     <= '0;
            x     <= '0;
            y     <= '0;
            rep   <= 1'b0;
          end
        end
        ROW_IN: begin
          if (s_fire) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_last  <= 1'b0;
            if (c_last) begin
              c     <= '0;
              state <= ROW_REP;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        ROW_REP: begin
          if (adv) begin
            m_valid <= 1'b1;
            m_data  <= rd_data;
            m_last  <= 1'b0;
            if (c_last) begin
              c <= '0;
              if (!x_last) begin
                x     <= x + 1'b1;
                state <= ROW_IN;
              end else begin
                x     <= '0;
                rep   <= 1'b0;
                state <= ROW_DUP;
              end
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        ROW_DUP: begin
          if (adv) begin
            m_valid <= 1'b1;
            m_data  <= rd_data;
            m_last  <= y_last && x_last
                       && rep && c_last;
            if (c_last) begin
              c   <= '0;
              rep <= !rep;
              if (rep) begin
                if (x_last) begin
                  x <= '0;
                  if (!y_last) begin
                    y     <= y + 1'b1;
                    state <= ROW_IN;
                  end else begin
                    state <= FIN;
                  end
                end else begin
                  x <= x + 1'b1;
                end
              end
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        FIN: begin
          // final beat drained or handshaking now
          if (adv) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
